lc3_mem_responder: RTL and testbench

- Memory-side responder for the CPU memory interface: answers the control FSM's CS/WE requests, issued through MAR/MDR, after a programmable number of wait states.
- Signals completion with a one-cycle ready pulse, which the FSM uses as its R condition.
- Contains the word-addressed 16-bit main memory and the memory-mapped keyboard/display registers at xFE00-xFE06.
- Replaces the simple RAM model under the top-level datapath.

---
 rtl/lc3_mem_responder.sv | 133 +++++++++++++
 tb/tb_lc3_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: wait-stated word memory plus the keyboard and
// display device registers at xFE00-xFE06, completing each access with a ready pulse.
module lc3_mem_responder #(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_BITS   = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CS,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] DataIn,
    output logic [15:0] out,
    output logic        ready,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready
);
    // state | meaning
    // IDLE  | waiting for CS
    // BUSY  | wait states counting down in cnt
    // DONE  | access completed, ready high; a new CS is accepted here as in IDLE

    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        we_q;
    logic [15:0] addr_q, din_q;
    logic        kb_full;
    logic [7:0]  kb_reg;

    logic [15:0] mem [DEPTH] = '{default: 16'h0000};

    logic        accept, complete, acc_we;
    logic        kbdr_rd, ddr_wr, mem_wr;
    logic [15:0] acc_addr, acc_din, rd_data;

    assign accept = (state != BUSY) && CS;

    // A zero-wait access completes on its sampling edge, so it works from the live bus
    assign complete = !RESET && (ZERO_WAIT ? accept : (state == BUSY && cnt == 4'd0));
    assign acc_we   = ZERO_WAIT ? WE     : we_q;
    assign acc_addr = ZERO_WAIT ? ADDR   : addr_q;
    assign acc_din  = ZERO_WAIT ? DataIn : din_q;

    assign kbdr_rd = complete && !acc_we && (acc_addr == 16'hFE02);
    assign ddr_wr  = complete &&  acc_we && (acc_addr == 16'hFE06) && !dsp_valid;
    assign mem_wr  = complete &&  acc_we && (acc_addr < 16'hFE00);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            we_q   <= 1'b0;
            addr_q <= 16'h0000;
            din_q  <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= WAIT_LOAD;
                we_q   <= WE;
                addr_q <= ADDR;
                din_q  <= DataIn;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = CS ? (ZERO_WAIT ? DONE : BUSY) : IDLE;
            BUSY:       if (cnt == 4'd0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == DONE);
    end

    always_comb begin
        rd_data = 16'h0000;
        if (acc_addr < 16'hFE00) begin
            rd_data = mem[acc_addr[ADDR_BITS-1:0]];
        end else begin
            case (acc_addr)
                16'hFE00: rd_data = {kb_full, 15'b0};
                16'hFE02: rd_data = {8'b0, kb_reg};
                16'hFE04: rd_data = {~dsp_valid, 15'b0};
                default:  rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out       <= 16'h0000;
            kb_full   <= 1'b0;
            kb_reg    <= 8'h00;
            dsp_valid <= 1'b0;
            dsp_data  <= 8'h00;
        end else begin
            if (complete && !acc_we) out <= rd_data;
            // A KBDR read frees the holding register in time for a same-edge character
            if (kb_valid && (!kb_full || kbdr_rd)) begin
                kb_reg  <= kb_data;
                kb_full <= 1'b1;
            end else if (kbdr_rd) begin
                kb_full <= 1'b0;
            end
            if (dsp_valid && dsp_ready) begin
                dsp_valid <= 1'b0;
            end else if (ddr_wr) begin
                dsp_valid <= 1'b1;
                dsp_data  <= acc_din[7:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_wr) mem[acc_addr[ADDR_BITS-1:0]] <= acc_din;
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: three instances (3/0/1 wait states, one with 8 address
// bits) share one stimulus stream and are compared each cycle against a transaction model.
module tb_lc3_mem_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CS = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] DataIn = 16'h0000;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        dsp_ready = 1'b0;

    logic [2:0]       d_ready, d_dv;
    logic [2:0][15:0] d_out;
    logic [2:0][7:0]  d_dd;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    lc3_mem_responder #(.WAIT_CYCLES(3), .ADDR_BITS(16)) u_w3 (
        .CLK(CLK), .RESET(RESET), .CS(CS), .WE(WE), .ADDR(ADDR), .DataIn(DataIn),
        .out(d_out[0]), .ready(d_ready[0]), .kb_valid(kb_valid), .kb_data(kb_data),
        .dsp_valid(d_dv[0]), .dsp_data(d_dd[0]), .dsp_ready(dsp_ready));

    lc3_mem_responder #(.WAIT_CYCLES(0), .ADDR_BITS(16)) u_w0 (
        .CLK(CLK), .RESET(RESET), .CS(CS), .WE(WE), .ADDR(ADDR), .DataIn(DataIn),
        .out(d_out[1]), .ready(d_ready[1]), .kb_valid(kb_valid), .kb_data(kb_data),
        .dsp_valid(d_dv[1]), .dsp_data(d_dd[1]), .dsp_ready(dsp_ready));

    lc3_mem_responder #(.WAIT_CYCLES(1), .ADDR_BITS(8)) u_a8 (
        .CLK(CLK), .RESET(RESET), .CS(CS), .WE(WE), .ADDR(ADDR), .DataIn(DataIn),
        .out(d_out[2]), .ready(d_ready[2]), .kb_valid(kb_valid), .kb_data(kb_data),
        .dsp_valid(d_dv[2]), .dsp_data(d_dd[2]), .dsp_ready(dsp_ready));

    function automatic int wc(input int i);
        case (i)
            0:       return 3;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int ab(input int i);
        return (i == 2) ? 8 : 16;
    endfunction

    // Model: an access sampled at edge n completes at edge n+W; the next may be sampled at n+W+1
    longint      cyc = 0;
    bit          m_pend [3];
    longint      m_done [3];
    longint      m_free [3];
    logic        m_we   [3];
    logic [15:0] m_a    [3];
    logic [15:0] m_d    [3];
    logic        m_ready[3];
    logic [15:0] m_out  [3];
    bit          m_kbf  [3];
    logic [7:0]  m_kbr  [3];
    logic        m_dv   [3];
    logic [7:0]  m_dd   [3];
    logic [15:0] mmem [int];

    task automatic step(input int i);
        bit          done, kbrd, dacc;
        logic        cwe;
        logic [15:0] ca, cd, rv;
        int          key;
        done = 0; kbrd = 0; dacc = 0; cwe = 0; ca = 0; cd = 0; rv = 0;
        if (m_pend[i] && cyc == m_done[i]) begin
            done = 1; m_pend[i] = 0;
            cwe = m_we[i]; ca = m_a[i]; cd = m_d[i];
        end else if (CS && cyc >= m_free[i]) begin
            m_free[i] = cyc + wc(i) + 1;
            if (wc(i) == 0) begin
                done = 1; cwe = WE; ca = ADDR; cd = DataIn;
            end else begin
                m_pend[i] = 1; m_done[i] = cyc + wc(i);
                m_we[i] = WE; m_a[i] = ADDR; m_d[i] = DataIn;
            end
        end
        m_ready[i] = done;
        if (done) begin
            key = i * 65536 + (int'(ca) & ((1 << ab(i)) - 1));
            if (!cwe) begin
                if (ca < 16'hFE00)       rv = mmem.exists(key) ? mmem[key] : 16'h0000;
                else if (ca == 16'hFE00) rv = m_kbf[i] ? 16'h8000 : 16'h0000;
                else if (ca == 16'hFE02) begin rv = {8'h00, m_kbr[i]}; kbrd = 1; end
                else if (ca == 16'hFE04) rv = m_dv[i] ? 16'h0000 : 16'h8000;
                else                     rv = 16'h0000;
                m_out[i] = rv;
            end else begin
                if (ca < 16'hFE00) mmem[key] = cd;
                else if (ca == 16'hFE06 && !m_dv[i]) dacc = 1;
            end
        end
        if (kbrd) m_kbf[i] = 0;
        if (kb_valid && !m_kbf[i]) begin m_kbr[i] = kb_data; m_kbf[i] = 1; end
        if (m_dv[i] && dsp_ready) m_dv[i] = 0;
        if (dacc) begin m_dv[i] = 1; m_dd[i] = cd[7:0]; end
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0; m_free[i] = 0; m_ready[i] = 0; m_out[i] = 16'h0000;
                m_kbf[i] = 0; m_kbr[i] = 8'h00; m_dv[i] = 0; m_dd[i] = 8'h00;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) step(i);
        end
    end

    task automatic check(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check("ready", i, {15'b0, d_ready[i]}, {15'b0, m_ready[i]});
                check("out", i, d_out[i], m_out[i]);
                check("dsp_valid", i, {15'b0, d_dv[i]}, {15'b0, m_dv[i]});
                check("dsp_data", i, {8'b0, d_dd[i]}, {8'b0, m_dd[i]});
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // One-cycle CS; ready must pulse once at edge n+3 / n+0 / n+1 for the three instances
    task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d);
        CS = 1'b1; WE = we; ADDR = a; DataIn = d;
        @(posedge CLK); #1;
        CS = 1'b0; WE = ~we; ADDR = ~a; DataIn = ~d;
        for (int j = 0; j < 6; j++) begin
            @(negedge CLK);
            check("lit_ready_w3", 0, {15'b0, d_ready[0]}, (j == 3) ? 16'd1 : 16'd0);
            check("lit_ready_w0", 1, {15'b0, d_ready[1]}, (j == 0) ? 16'd1 : 16'd0);
            check("lit_ready_w1", 2, {15'b0, d_ready[2]}, (j == 1) ? 16'd1 : 16'd0);
            if (j < 5) @(posedge CLK);
        end
        tick();
    endtask

    task automatic lit(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
        @(negedge CLK);
        check(name, inst, act, exp);
        tick();
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check("lit_rst_out", i, d_out[i], 16'h0000);
            check("lit_rst_ready", i, {15'b0, d_ready[i]}, 16'h0000);
            check("lit_rst_dsp_valid", i, {15'b0, d_dv[i]}, 16'h0000);
        end
        tick();
        RESET = 1'b0;
        tick();

        access(1'b1, 16'h3000, 16'h1234);
        access(1'b0, 16'h3000, 16'h0000);
        lit("lit_rd3000", 0, d_out[0], 16'h1234);
        lit("lit_rd3000", 1, d_out[1], 16'h1234);
        lit("lit_rd3000_alias", 2, d_out[2], 16'h1234);

        // Back-to-back zero-wait reads with CS held high
        access(1'b1, 16'h0005, 16'hAAAA);
        access(1'b1, 16'h0006, 16'hBBBB);
        CS = 1'b1; WE = 1'b0; ADDR = 16'h0005;
        tick();
        ADDR = 16'h0006;
        @(negedge CLK);
        check("lit_b2b_ready0", 1, {15'b0, d_ready[1]}, 16'h0001);
        check("lit_b2b_out0", 1, d_out[1], 16'hAAAA);
        tick();
        CS = 1'b0; ADDR = 16'h0000;
        @(negedge CLK);
        check("lit_b2b_ready1", 1, {15'b0, d_ready[1]}, 16'h0001);
        check("lit_b2b_out1", 1, d_out[1], 16'hBBBB);
        tick();
        @(negedge CLK);
        check("lit_b2b_ready2", 1, {15'b0, d_ready[1]}, 16'h0000);
        repeat (5) tick();
        lit("lit_b2b_w3_out", 0, d_out[0], 16'hAAAA);

        // Keyboard: x41 captured, x42 lost while full
        kb_valid = 1'b1; kb_data = 8'h41;
        tick();
        kb_data = 8'h42;
        tick();
        kb_valid = 1'b0;
        access(1'b0, 16'hFE00, 16'h0000);
        lit("lit_kbsr_full", 0, d_out[0], 16'h8000);
        access(1'b0, 16'hFE02, 16'h0000);
        lit("lit_kbdr", 0, d_out[0], 16'h0041);
        access(1'b0, 16'hFE00, 16'h0000);
        lit("lit_kbsr_empty", 0, d_out[0], 16'h0000);
        kb_valid = 1'b1; kb_data = 8'h43;
        tick();
        kb_data = 8'h44;
        access(1'b0, 16'hFE02, 16'h0000);
        kb_valid = 1'b0;
        lit("lit_kbdr_same_edge", 1, d_out[1], 16'h0043);
        access(1'b0, 16'hFE00, 16'h0000);
        lit("lit_kbsr_refill", 2, d_out[2], 16'h8000);
        access(1'b0, 16'hFE02, 16'h0000);
        lit("lit_kbdr_new", 0, d_out[0], 16'h0044);

        // Display
        dsp_ready = 1'b0;
        access(1'b1, 16'hFE06, 16'h0058);
        lit("lit_dsp_valid", 0, {15'b0, d_dv[0]}, 16'h0001);
        lit("lit_dsp_data", 0, {8'b0, d_dd[0]}, 16'h0058);
        access(1'b0, 16'hFE04, 16'h0000);
        lit("lit_dsr_busy", 0, d_out[0], 16'h0000);
        access(1'b1, 16'hFE06, 16'h0059);
        lit("lit_ddr_dropped", 0, {8'b0, d_dd[0]}, 16'h0058);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        lit("lit_dsp_cleared", 0, {15'b0, d_dv[0]}, 16'h0000);
        access(1'b0, 16'hFE04, 16'h0000);
        lit("lit_dsr_ready", 0, d_out[0], 16'h8000);
        access(1'b1, 16'hFE06, 16'h005A);
        dsp_ready = 1'b1; CS = 1'b1; WE = 1'b1; ADDR = 16'hFE06; DataIn = 16'h005B;
        tick();
        dsp_ready = 1'b0; CS = 1'b0;
        repeat (5) tick();
        lit("lit_ddr_same_edge_drop", 1, {15'b0, d_dv[1]}, 16'h0000);
        lit("lit_ddr_late_accept", 0, {8'b0, d_dd[0]}, 16'h005B);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;

        // Reset in the middle of a write
        CS = 1'b1; WE = 1'b1; ADDR = 16'h4000; DataIn = 16'h9999;
        tick();
        CS = 1'b0;
        tick();
        RESET = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            check("lit_abort_no_ready", 0, {15'b0, d_ready[0]}, 16'h0000);
            tick();
        end
        RESET = 1'b0;
        tick();
        access(1'b0, 16'h3000, 16'h0000);
        lit("lit_mem_survives_reset", 0, d_out[0], 16'h1234);
        access(1'b0, 16'h4000, 16'h0000);
        lit("lit_aborted_write", 0, d_out[0], 16'h0000);

        // Aliasing with 8 address bits, and an unmapped device address
        access(1'b1, 16'h0105, 16'h00FF);
        access(1'b0, 16'h0005, 16'h0000);
        lit("lit_alias", 2, d_out[2], 16'h00FF);
        lit("lit_no_alias", 0, d_out[0], 16'hAAAA);
        access(1'b0, 16'hFE10, 16'h0000);
        lit("lit_unmapped", 2, d_out[2], 16'h0000);
        lit("lit_unmapped", 0, d_out[0], 16'h0000);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
